// File: rtl/cpu_bus_checker_if.sv
// Sampled bus of NUM_CH CPU instances feeding the lockstep checker.
// Channel i occupies bits [i*AW +: AW] / [i*DW +: DW] of the packed buses.
interface cpu_bus_checker_if #(
  parameter int NUM_CH = 2,
  parameter int AW     = 16,
  parameter int DW     = 8
);
  logic [NUM_CH-1:0]    ch_valid;
  logic [NUM_CH*AW-1:0] ch_addr;
  logic [NUM_CH*DW-1:0] ch_data;
  logic [NUM_CH-1:0]    ch_wen;
  logic [NUM_CH-1:0]    ch_ren;

  modport master (
    output ch_valid, ch_addr, ch_data,
    output ch_wen, ch_ren
  );

  modport slave (
    input ch_valid, ch_addr, ch_data,
    input ch_wen, ch_ren
  );
endinterface

// File: rtl/cpu_bus_checker.sv
// Lockstep bus checker: channel 0 is golden, others compared through
// per-channel skew FIFOs; reports first divergence, overflow and sync loss.
module cpu_bus_checker #(
  parameter int NUM_CH  = 2,
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int CW      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              halt_on_err,
  input  logic              clear,
  cpu_bus_checker_if.slave  bus,
  output logic              mismatch,
  output logic [NUM_CH-1:0] err_mask,
  output logic [CW-1:0]     first_err_idx,
  output logic [NUM_CH-1:0] first_err_mask,
  output logic [AW-1:0]     first_err_addr,
  output logic [15:0]       err_cnt,
  output logic [CW-1:0]     txn_count,
  output logic              overflow,
  output logic              timeout,
  output logic [1:0]        state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          wen;
    logic          ren;
  } ent_t;

  ent_t        mem  [NUM_CH][DEPTH];
  ent_t        din  [NUM_CH];
  ent_t        head [NUM_CH];
  logic [PW:0] wp   [NUM_CH];
  logic [PW:0] rp   [NUM_CH];

  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] ovf;
  logic [NUM_CH-1:0] mask;
  logic              run;
  logic              pop;
  logic              flush;
  logic              has_err;
  logic [SW-1:0]     skew;

  assign run   = (state == ST_RUN) && en && !clear;
  assign flush = clear || !en;
  assign pop   = run && ~|empty;

  always_comb begin
    empty = '0;
    full  = '0;
    push  = '0;
    ovf   = '0;
    mask  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      din[i].addr = bus.ch_addr[i*AW +: AW];
      din[i].data = bus.ch_data[i*DW +: DW];
      din[i].wen  = bus.ch_wen[i];
      din[i].ren  = bus.ch_ren[i];
      head[i]  = mem[i][rp[i][PW-1:0]];
      empty[i] = (wp[i] == rp[i]);
      full[i]  = (wp[i][PW-1:0] == rp[i][PW-1:0])
              && (wp[i][PW] != rp[i][PW]);
    end
    // a pop in the same cycle frees the slot a full FIFO needs
    for (int i = 0; i < NUM_CH; i++) begin
      push[i] = run && bus.ch_valid[i]
             && (!full[i] || pop);
      ovf[i]  = run && bus.ch_valid[i]
             && full[i] && !pop;
    end
    for (int k = 1; k < NUM_CH; k++) begin
      mask[k] = pop && (
          (head[k].addr != head[0].addr)
       || (head[k].wen  != head[0].wen)
       || (head[k].ren  != head[0].ren)
       || (head[0].wen
           && (head[k].data != head[0].data)));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        mem[i][wp[i][PW-1:0]] <= din[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        wp[i] <= wp[i] + {{PW{1'b0}}, push[i]};
        rp[i] <= rp[i] + {{PW{1'b0}}, pop};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      mismatch       <= 1'b0;
      err_mask       <= '0;
      first_err_idx  <= '0;
      first_err_mask <= '0;
      first_err_addr <= '0;
      err_cnt        <= '0;
      txn_count      <= '0;
      overflow       <= 1'b0;
      timeout        <= 1'b0;
      has_err        <= 1'b0;
      skew           <= '0;
    end else begin
      mismatch <= 1'b0;
      err_mask <= '0;
      if (clear) begin
        first_err_idx  <= '0;
        first_err_mask <= '0;
        first_err_addr <= '0;
        err_cnt        <= '0;
        txn_count      <= '0;
        overflow       <= 1'b0;
        timeout        <= 1'b0;
        has_err        <= 1'b0;
        skew           <= '0;
        state          <= en ? ST_RUN : ST_IDLE;
      end else if (!en) begin
        skew  <= '0;
        state <= ST_IDLE;
      end else begin
        unique case (1'b1)
          (state == ST_IDLE): state <= ST_RUN;
          (state == ST_RUN): begin
            if (pop) begin
              mismatch <= |mask;
              err_mask <= mask;
              if (txn_count != '1)
                txn_count <= txn_count + CW'(1);
              if (|mask) begin
                if (err_cnt != 16'hFFFF)
                  err_cnt <= err_cnt + 16'd1;
                if (!has_err) begin
                  has_err        <= 1'b1;
                  first_err_idx  <= txn_count;
                  first_err_mask <= mask;
                  first_err_addr <= head[0].addr;
                end
                if (halt_on_err) state <= ST_HALT;
              end
            end
            if (pop || &empty) begin
              skew <= '0;
            end else if (|empty) begin
              skew <= skew + SW'(1);
              if (skew == SW'(TIMEOUT - 1)) begin
                timeout <= 1'b1;
                state   <= ST_ERR;
              end
            end
            // overflow outranks a halting mismatch
            if (|ovf) begin
              overflow <= 1'b1;
              state    <= ST_ERR;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_checker.sv
// Directed bench for cpu_bus_checker: vector table plus
// hand-written halt, skew, overflow, timeout and reset sequences.
module tb_cpu_bus_checker;
  localparam int NCH = 3;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int CW  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic halt_on_err = 1'b0;
  logic clear = 1'b0;

  logic           mismatch;
  logic [NCH-1:0] err_mask;
  logic [CW-1:0]  first_err_idx;
  logic [NCH-1:0] first_err_mask;
  logic [AW-1:0]  first_err_addr;
  logic [15:0]    err_cnt;
  logic [CW-1:0]  txn_count;
  logic           overflow;
  logic           timeout;
  logic [1:0]     state;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_bus_checker_if #(.NUM_CH(NCH), .AW(AW), .DW(DW)) bif ();

  cpu_bus_checker #(
    .NUM_CH(NCH), .AW(AW), .DW(DW),
    .DEPTH(8), .TIMEOUT(64), .CW(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .halt_on_err(halt_on_err),
    .clear(clear),
    .bus(bif.slave),
    .mismatch(mismatch),
    .err_mask(err_mask),
    .first_err_idx(first_err_idx),
    .first_err_mask(first_err_mask),
    .first_err_addr(first_err_addr),
    .err_cnt(err_cnt),
    .txn_count(txn_count),
    .overflow(overflow),
    .timeout(timeout),
    .state(state)
  );

  typedef struct packed {
    logic [2:0][15:0] a;
    logic [2:0][7:0]  d;
    logic [2:0]       w;
    logic [2:0]       r;
    logic [2:0]       m;
  } vec_t;

  vec_t vt [8];

  function automatic vec_t mk(
    input logic [15:0] a0, a1, a2,
    input logic [7:0]  d0, d1, d2,
    input logic [2:0]  w, r, m
  );
    vec_t v;
    v.a = {a2, a1, a0};
    v.d = {d2, d1, d0};
    v.w = w;
    v.r = r;
    v.m = m;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input int i, input logic v,
                       input logic [15:0] a,
                       input logic [7:0] d,
                       input logic w, input logic r);
    bif.ch_valid[i]          = v;
    bif.ch_addr[i*AW +: AW]  = a;
    bif.ch_data[i*DW +: DW]  = d;
    bif.ch_wen[i]            = w;
    bif.ch_ren[i]            = r;
  endtask

  task automatic idle();
    bif.ch_valid = '0;
  endtask

  task automatic all_push(input logic [15:0] a,
                          input logic [7:0] d,
                          input logic w, input logic r);
    for (int i = 0; i < NCH; i++) drive(i, 1'b1, a, d, w, r);
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_state"}, 64'(state), 64'd0);
    chk({nm, "_mismatch"}, 64'(mismatch), 64'd0);
    chk({nm, "_err_mask"}, 64'(err_mask), 64'd0);
    chk({nm, "_txn"}, 64'(txn_count), 64'd0);
    chk({nm, "_err_cnt"}, 64'(err_cnt), 64'd0);
    chk({nm, "_fidx"}, 64'(first_err_idx), 64'd0);
    chk({nm, "_fmask"}, 64'(first_err_mask), 64'd0);
    chk({nm, "_faddr"}, 64'(first_err_addr), 64'd0);
    chk({nm, "_ovf"}, 64'(overflow), 64'd0);
    chk({nm, "_tmo"}, 64'(timeout), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    bif.ch_valid = '0;
    bif.ch_addr  = '0;
    bif.ch_data  = '0;
    bif.ch_wen   = '0;
    bif.ch_ren   = '0;

    vt[0] = mk(16'h1000, 16'h1000, 16'h1000,
               8'h11, 8'h11, 8'h11, 3'b111, 3'b000, 3'b000);
    vt[1] = mk(16'h1004, 16'h1005, 16'h1004,
               8'h22, 8'h22, 8'h22, 3'b111, 3'b000, 3'b010);
    vt[2] = mk(16'h1008, 16'h1008, 16'h1008,
               8'hA5, 8'hA5, 8'h5A, 3'b111, 3'b000, 3'b100);
    vt[3] = mk(16'h100C, 16'h100C, 16'h100C,
               8'hA5, 8'hA5, 8'h5A, 3'b000, 3'b111, 3'b000);
    vt[4] = mk(16'h1010, 16'h1010, 16'h1010,
               8'h33, 8'h33, 8'h33, 3'b101, 3'b100, 3'b110);
    vt[5] = mk(16'h1014, 16'h1014, 16'h1014,
               8'h44, 8'h55, 8'h66, 3'b000, 3'b111, 3'b000);
    vt[6] = mk(16'h1018, 16'h1018, 16'h1018,
               8'h77, 8'h77, 8'h77, 3'b000, 3'b101, 3'b010);
    vt[7] = mk(16'h101C, 16'h101C, 16'h101C,
               8'h88, 8'h88, 8'h88, 3'b000, 3'b111, 3'b000);

    // reset and enable
    #12;
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    chk("idle_en0", 64'(state), 64'd0);
    en = 1'b1;
    tick();
    chk("idle_to_run", 64'(state), 64'd1);

    // vector table, one compare at a time, no halting
    for (int j = 0; j < 8; j++) begin
      for (int c = 0; c < NCH; c++)
        drive(c, 1'b1, vt[j].a[c], vt[j].d[c],
              vt[j].w[c], vt[j].r[c]);
      tick();
      idle();
      tick();
      chk($sformatf("vec%0d_mismatch", j),
          64'(mismatch), 64'(vt[j].m != 3'b000));
      chk($sformatf("vec%0d_err_mask", j),
          64'(err_mask), 64'(vt[j].m));
    end
    tick();
    chk("tbl_mismatch_pulse", 64'(mismatch), 64'd0);
    chk("tbl_txn", 64'(txn_count), 64'd8);
    chk("tbl_err_cnt", 64'(err_cnt), 64'd4);
    chk("tbl_fidx", 64'(first_err_idx), 64'd1);
    chk("tbl_fmask", 64'(first_err_mask), 64'h2);
    chk("tbl_faddr", 64'(first_err_addr), 64'h1004);
    chk("tbl_state", 64'(state), 64'd1);

    do_clear();
    chk("clr_txn", 64'(txn_count), 64'd0);
    chk("clr_err_cnt", 64'(err_cnt), 64'd0);
    chk("clr_fidx", 64'(first_err_idx), 64'd0);
    chk("clr_state", 64'(state), 64'd1);

    // 100 identical transactions back to back
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      all_push(16'(16'h4000 + i), 8'(i * 7), i[0], !i[0]);
      tick();
      if (mismatch) seen = 1'b1;
      if (i == 50)
        chk("stream_latency", 64'(txn_count), 64'd50);
    end
    idle();
    tick();
    if (mismatch) seen = 1'b1;
    chk("stream_no_mm", 64'(seen), 64'd0);
    chk("stream_txn", 64'(txn_count), 64'd100);
    chk("stream_err_cnt", 64'(err_cnt), 64'd0);
    chk("stream_state", 64'(state), 64'd1);

    // write-data divergence on txn 7 with halt
    halt_on_err = 1'b1;
    do_clear();
    for (int i = 0; i < 8; i++) begin
      all_push(16'(16'h5000 + i), 8'hA5, 1'b1, 1'b0);
      if (i == 7) drive(2, 1'b1, 16'h5007, 8'h5A, 1'b1, 1'b0);
      tick();
      if (i == 7)
        chk("halt_pre_mm", 64'(mismatch), 64'd0);
    end
    idle();
    tick();
    chk("halt_mm", 64'(mismatch), 64'd1);
    chk("halt_mask", 64'(err_mask), 64'h4);
    chk("halt_fidx", 64'(first_err_idx), 64'd7);
    chk("halt_fmask", 64'(first_err_mask), 64'h4);
    chk("halt_faddr", 64'(first_err_addr), 64'h5007);
    chk("halt_state", 64'(state), 64'd2);
    chk("halt_txn", 64'(txn_count), 64'd8);
    chk("halt_err_cnt", 64'(err_cnt), 64'd1);
    all_push(16'h5100, 8'h00, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    tick();
    chk("halt_frozen_txn", 64'(txn_count), 64'd8);
    chk("halt_frozen_state", 64'(state), 64'd2);
    chk("halt_mm_low", 64'(mismatch), 64'd0);

    // same data difference, but on a read
    do_clear();
    chk("rd_clr_state", 64'(state), 64'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        all_push(16'h5007, 8'hA5, 1'b0, 1'b1);
        drive(2, 1'b1, 16'h5007, 8'h5A, 1'b0, 1'b1);
      end else begin
        all_push(16'(16'h5000 + i), 8'hA5, 1'b1, 1'b0);
      end
      tick();
    end
    idle();
    tick();
    chk("rd_mm", 64'(mismatch), 64'd0);
    chk("rd_txn", 64'(txn_count), 64'd8);
    chk("rd_state", 64'(state), 64'd1);

    // channel 1 lags by 3 cycles
    do_clear();
    seen = 1'b0;
    for (int c = 0; c < 13; c++) begin
      idle();
      if (c < 10) begin
        drive(0, 1'b1, 16'(16'h2000 + c), 8'(c), 1'b1, 1'b0);
        drive(2, 1'b1, 16'(16'h2000 + c), 8'(c), 1'b1, 1'b0);
      end
      if (c >= 3)
        drive(1, 1'b1, 16'(16'h2000 + c - 3), 8'(c - 3),
              1'b1, 1'b0);
      tick();
      if (mismatch) seen = 1'b1;
    end
    idle();
    tick();
    if (mismatch) seen = 1'b1;
    chk("lag_no_mm", 64'(seen), 64'd0);
    chk("lag_txn", 64'(txn_count), 64'd10);
    chk("lag_ovf", 64'(overflow), 64'd0);
    chk("lag_state", 64'(state), 64'd1);

    // channel 1 silent for 9 pushes: ninth overflows
    do_clear();
    for (int c = 0; c < 9; c++) begin
      idle();
      drive(0, 1'b1, 16'(16'h3000 + c), 8'(c), 1'b1, 1'b0);
      drive(2, 1'b1, 16'(16'h3000 + c), 8'(c), 1'b1, 1'b0);
      tick();
      if (c == 7) begin
        chk("ovf_pre_flag", 64'(overflow), 64'd0);
        chk("ovf_pre_state", 64'(state), 64'd1);
      end
    end
    idle();
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_state", 64'(state), 64'd3);
    chk("ovf_txn", 64'(txn_count), 64'd0);

    // channel 1 stops after 5 transactions
    do_clear();
    chk("tmo_clr_ovf", 64'(overflow), 64'd0);
    chk("tmo_clr_state", 64'(state), 64'd1);
    for (int c = 0; c < 6; c++) begin
      idle();
      drive(0, 1'b1, 16'(16'h6000 + c), 8'(c), 1'b1, 1'b0);
      drive(2, 1'b1, 16'(16'h6000 + c), 8'(c), 1'b1, 1'b0);
      if (c < 5)
        drive(1, 1'b1, 16'(16'h6000 + c), 8'(c), 1'b1, 1'b0);
      tick();
    end
    idle();
    chk("tmo_txn", 64'(txn_count), 64'd5);
    seen = 1'b0;
    for (int k = 6; k < 69; k++) begin
      tick();
      if (timeout) seen = 1'b1;
    end
    chk("tmo_early", 64'(seen), 64'd0);
    chk("tmo_pre_state", 64'(state), 64'd1);
    tick();
    chk("tmo_flag", 64'(timeout), 64'd1);
    chk("tmo_state", 64'(state), 64'd3);
    do_clear();
    chk("tmo_clr_flag", 64'(timeout), 64'd0);
    chk("tmo_clr_ovf2", 64'(overflow), 64'd0);
    chk("tmo_clr_state2", 64'(state), 64'd1);
    chk("tmo_clr_txn", 64'(txn_count), 64'd0);

    // async reset with FIFOs partly filled
    halt_on_err = 1'b0;
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c < 2) begin
        all_push(16'(16'h6100 + c), 8'h10, 1'b1, 1'b0);
      end else begin
        drive(0, 1'b1, 16'(16'h6100 + c), 8'h10, 1'b1, 1'b0);
        drive(2, 1'b1, 16'(16'h6100 + c), 8'h10, 1'b1, 1'b0);
      end
      tick();
    end
    idle();
    chk("rst_pre_txn", 64'(txn_count), 64'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    #2;
    rst_n = 1'b1;
    tick();
    chk("rst_run", 64'(state), 64'd1);
    all_push(16'h7777, 8'h77, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    chk("rst_fresh_mm", 64'(mismatch), 64'd0);
    chk("rst_fresh_txn", 64'(txn_count), 64'd1);

    // en=0 forces IDLE but keeps counters
    en = 1'b0;
    tick();
    chk("en0_state", 64'(state), 64'd0);
    chk("en0_txn_kept", 64'(txn_count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
